// File: rtl/apb_reg_pkg.sv
// Shared types and address decode for the APB register slave.
package apb_reg_pkg;

  localparam int unsigned APB_DATA_W    = 32;
  localparam int unsigned APB_STRB_W    = APB_DATA_W / 8;
  localparam int unsigned APB_DEC_IDX_W = 16;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_state_e;

  typedef struct packed {
    logic [APB_DEC_IDX_W-1:0] idx;
    logic                     err;
  } apb_dec_t;

  // Word index within the window plus alignment/range error.
  function automatic apb_dec_t apb_decode(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input int unsigned num_regs);
    apb_dec_t    d;
    logic [63:0] off;
    off   = addr - base;
    d.idx = APB_DEC_IDX_W'(off >> 2);
    d.err = (addr[1:0] != 2'b00) || (addr < base) || (off >= (64'(num_regs) << 2));
    return d;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// RW word storage with byte-strobe write port; RO slots read from hardware inputs.
module apb_reg_bank
  import apb_reg_pkg::*;
#(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_REGS = 16,
  parameter int unsigned         IDX_W    = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK  = NUM_REGS'(1)
) (
  input  logic                         pclk,
  input  logic                         presetn,
  input  logic                         we,
  input  logic [IDX_W-1:0]             idx,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_data_i,
  output logic [DATA_W-1:0]            rdata_c,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    logic [DATA_W-1:0] q;

    if (RO_MASK[i]) begin : g_ro
      assign q = '0;
    end else begin : g_rw
      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          q <= '0;
        end else if (we && (idx == IDX_W'(i))) begin
          for (int b = 0; b < int'(STRB_W); b++) begin
            if (wstrb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end

    assign regs_o[i*DATA_W +: DATA_W] = q;
  end

  always_comb begin
    rdata_c = regs_o[32'(idx)*DATA_W +: DATA_W];
    if (RO_MASK[idx]) rdata_c = ro_data_i[32'(idx)*DATA_W +: DATA_W];
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer for a CSR bank: wait states, byte strobes, RO hardware regs, PSLVERR decode.
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = '0,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = NUM_REGS'(1)
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [2:0]                 pprot,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [DATA_W/8-1:0]        pstrb,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  input  logic [NUM_REGS*DATA_W-1:0] ro_data_i
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W  = 4;

  apb_state_e          state, next_c;
  logic [CNT_W-1:0]    wait_cnt;
  logic [IDX_W-1:0]    cap_idx;
  logic                cap_write;
  logic                cap_err;
  logic [DATA_W-1:0]   cap_wdata;
  logic [STRB_W-1:0]   cap_strb;

  apb_dec_t            dec_c;
  logic                err_c;
  logic                capture_c;
  logic                we_c;
  logic [DATA_W-1:0]   rdata_c;
  logic                unused_c;

  // Decode at SETUP capture time; RO hit only matters for writes.
  always_comb begin
    dec_c = apb_decode(64'(paddr), 64'(BASE_ADDR), NUM_REGS);
    err_c = dec_c.err || (pwrite && RO_MASK[dec_c.idx[IDX_W-1:0]]);
  end

  assign unused_c = ^{pprot, dec_c.idx[APB_DEC_IDX_W-1:IDX_W]};

  always_comb begin
    next_c = state;
    case (state)
      IDLE:   if (psel && !penable) next_c = SETUP;
      SETUP: begin
        if (!psel)        next_c = IDLE;
        else if (penable) next_c = (WAIT_STATES > 0) ? WAIT : ACCESS;
      end
      WAIT: begin
        if (!psel)                                    next_c = IDLE;
        else if (wait_cnt == CNT_W'(WAIT_STATES - 1)) next_c = ACCESS;
      end
      ACCESS: next_c = (psel && !penable) ? SETUP : IDLE;
      default: next_c = IDLE;
    endcase
  end

  assign capture_c = (next_c == SETUP) && (state != SETUP);
  assign we_c      = (state == ACCESS) && cap_write && !cap_err;

  // State, wait counter, captured request and registered bus outputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pready    <= 1'b0;
      prdata    <= '0;
      pslverr   <= 1'b0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_wdata <= '0;
      cap_strb  <= '0;
    end else begin
      state    <= next_c;
      wait_cnt <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
      pready   <= (next_c == ACCESS);
      pslverr  <= (next_c == ACCESS) && cap_err;
      prdata   <= ((next_c == ACCESS) && !cap_write && !cap_err) ? rdata_c : '0;
      if (capture_c) begin
        cap_idx   <= dec_c.idx[IDX_W-1:0];
        cap_write <= pwrite;
        cap_err   <= err_c;
        cap_wdata <= pwdata;
        cap_strb  <= pstrb;
      end
    end
  end

  apb_reg_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RO_MASK  (RO_MASK)
  ) u_bank (
    .pclk      (pclk),
    .presetn   (presetn),
    .we        (we_c),
    .idx       (cap_idx),
    .wdata     (cap_wdata),
    .wstrb     (cap_strb),
    .ro_data_i (ro_data_i),
    .rdata_c   (rdata_c),
    .regs_o    (regs_o)
  );

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: zero-wait and three-wait-state instances on a shared bus.
module tb_apb_reg_slave;

  localparam int unsigned NR = 16;
  localparam int unsigned DW = 32;

  logic             pclk = 1'b0;
  logic             presetn = 1'b0;
  logic [31:0]      paddr = '0;
  logic [2:0]       pprot = '0;
  logic             psel = 1'b0;
  logic             penable = 1'b0;
  logic             pwrite = 1'b0;
  logic [DW-1:0]    pwdata = '0;
  logic [3:0]       pstrb = '0;
  logic             sel = 1'b0;
  logic [NR*DW-1:0] ro_data;

  logic             pready0, pready3, pslverr0, pslverr3;
  logic [DW-1:0]    prdata0, prdata3;
  logic [NR*DW-1:0] regs0, regs3;
  logic             psel0, psel3, pready, pslverr;
  logic [DW-1:0]    prdata;

  assign psel0   = psel & ~sel;
  assign psel3   = psel & sel;
  assign pready  = sel ? pready3 : pready0;
  assign pslverr = sel ? pslverr3 : pslverr0;
  assign prdata  = sel ? prdata3 : prdata0;

  always #5 pclk = ~pclk;

  apb_reg_slave #(.WAIT_STATES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .psel(psel0),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready0), .prdata(prdata0), .pslverr(pslverr0), .regs_o(regs0),
    .ro_data_i(ro_data));

  apb_reg_slave #(.WAIT_STATES(3)) dut3 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pprot(pprot), .psel(psel3),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready3), .prdata(prdata3), .pslverr(pslverr3), .regs_o(regs3),
    .ro_data_i(ro_data));

  int applied = 0;
  int miscompares = 0;
  logic [DW-1:0] mdl [NR];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_regs(input string name, input logic [NR*DW-1:0] act);
    logic [NR*DW-1:0] exp;
    for (int i = 0; i < int'(NR); i++) exp[i*DW +: DW] = (i == 0) ? '0 : mdl[i];
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer; returns at the negedge where pready is seen (psel/penable left high).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int cyc);
    int n;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
    cyc = 1;
    @(posedge pclk); #1;
    penable = 1'b1; cyc = 2;
    paddr = a ^ 32'h4; pwdata = ~wd; pstrb = ~s;
    n = 0;
    @(negedge pclk);
    while (pready !== 1'b1 && n < 40) begin
      chk("wait_outs_zero", {31'd0, pslverr, prdata}, 64'd0);
      @(negedge pclk);
      cyc++; n++;
    end
    if (n >= 40) chk("pready_timeout", 64'(n), 64'd0);
    rd = prdata;
    er = pslverr;
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][b*8 +: 8] = wd[b*8 +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    logic        seen;

    for (int i = 0; i < int'(NR); i++) begin
      mdl[i] = '0;
      ro_data[i*DW +: DW] = 32'hFFFF_FFFF - 32'(i);
    end
    ro_data[31:0] = 32'h0A5A_0001;

    vt[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h08, 32'h11223344, 4'h5, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 32'hAA22CC44, 1'b0};
    vt[5]  = '{1'b1, 32'h00, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vt[6]  = '{1'b1, 32'h02, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vt[7]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0A5A0001, 1'b0};
    vt[9]  = '{1'b0, 32'h02, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[10] = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
    vt[11] = '{1'b1, 32'h0C, 32'hCAFEF00D, 4'h0, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h0C, 32'h0,        4'h0, 32'h0,        1'b0};
    vt[13] = '{1'b1, 32'h3C, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vt[14] = '{1'b0, 32'h3C, 32'h0,        4'h0, 32'h12345678, 1'b0};

    // Reset state
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_outs0", {31'd0, pslverr0, pready0, prdata0}, 64'd0);
    chk("rst_outs3", {31'd0, pslverr3, pready3, prdata3}, 64'd0);
    chk_regs("rst_regs0", regs0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    // Table vectors on the zero-wait instance
    sel = 1'b0;
    for (int i = 0; i < 15; i++) begin
      xfer(vt[i].w, vt[i].a, vt[i].wd, vt[i].s, rd, er, cyc);
      chk($sformatf("v%0d_prdata", i), 64'(rd), 64'(vt[i].erd));
      chk($sformatf("v%0d_pslverr", i), 64'(er), 64'(vt[i].eerr));
      chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'd3);
      bus_idle();
      if (vt[i].w && !vt[i].eerr) mdl_write(vt[i].a, vt[i].wd, vt[i].s);
      chk_regs($sformatf("v%0d_regs", i), regs0);
    end

    // Back-to-back write then read, no idle between
    xfer(1'b1, 32'h10, 32'h5555AAAA, 4'hF, rd, er, cyc);
    chk("b2b_wr_err", 64'(er), 64'd0);
    chk("b2b_wr_cycles", 64'(cyc), 64'd3);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    chk("b2b_rd_data", 64'(rd), 64'h5555AAAA);
    chk("b2b_rd_cycles", 64'(cyc), 64'd3);
    bus_idle();
    mdl_write(32'h10, 32'h5555AAAA, 4'hF);
    chk_regs("b2b_regs", regs0);

    // Three wait states: RO read then write
    sel = 1'b1;
    xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, cyc);
    chk("ws3_ro_data", 64'(rd), 64'h0A5A0001);
    chk("ws3_ro_err", 64'(er), 64'd0);
    chk("ws3_ro_cycles", 64'(cyc), 64'd6);
    bus_idle();
    xfer(1'b1, 32'h04, 32'h01020304, 4'hF, rd, er, cyc);
    chk("ws3_wr_cycles", 64'(cyc), 64'd6);
    bus_idle();
    chk("ws3_wr_reg", 64'(regs3[1*DW +: DW]), 64'h01020304);

    // Abort in WAIT by dropping psel: no completion, no write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge pclk);
      seen = seen | pready;
    end
    chk("abort_no_pready", 64'(seen), 64'd0);
    chk("abort_no_write", 64'(regs3[3*DW +: DW]), 64'd0);

    // Reset during WAIT of a write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h77777777; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #2;
    presetn = 1'b0;
    #1;
    chk("midrst_outs", {31'd0, pslverr, pready, prdata}, 64'd0);
    for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
    chk_regs("midrst_regs3", regs3);
    chk_regs("midrst_regs0", regs0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(1'b1, 32'h08, 32'h13579BDF, 4'hF, rd, er, cyc);
    chk("postrst_wr_err", 64'(er), 64'd0);
    chk("postrst_wr_cycles", 64'(cyc), 64'd6);
    bus_idle();
    xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
    chk("postrst_rd_data", 64'(rd), 64'h13579BDF);
    chk("postrst_rd_cycles", 64'(cyc), 64'd6);
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
